// File: rtl/prog_pkg.sv
// Shared types and constants for the instruction-fetch slice.
package prog_pkg;
  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 27;
  localparam int OP_HI   = 26;
  localparam int OP_LO   = 21;
  localparam logic [OP_HI-OP_LO:0] HALT_OP = 6'h3F;

  typedef enum logic {RUN, HALT} fetch_state_t;
  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [INSTR_W-1:0] instr_t;
endpackage

// File: rtl/prog_fetch.sv
// Instruction-fetch unit: owns the PC, reads progMem combinationally and
// registers the returned word for decode. Supports stall, redirect and sticky halt.
module prog_fetch
  import prog_pkg::*;
#(
  parameter int                ADDR_W   = prog_pkg::ADDR_W,
  parameter int                INSTR_W  = prog_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               Clk,
  input  logic               Reset,
  output logic [ADDR_W-1:0]  Address,
  input  logic [INSTR_W-1:0] Data_In,
  input  logic               Stall,
  input  logic               Branch_En,
  input  logic [ADDR_W-1:0]  Branch_Target,
  output logic [INSTR_W-1:0] Instr,
  output logic [ADDR_W-1:0]  Instr_PC,
  output logic               Instr_Valid,
  output logic               Halted
);

  fetch_state_t       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
  logic               vld_q, vld_d;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    vld_d      = vld_q;
    if (state_q == RUN) begin
      // Redirect wins over stall; the stalled instruction is simply dropped.
      if (Branch_En) begin
        pc_d  = Branch_Target;
        vld_d = 1'b0;
      end else if (!Stall) begin
        instr_d    = Data_In;
        instr_pc_d = pc_q;
        vld_d      = 1'b1;
        pc_d       = pc_q + ADDR_W'(1);
        if (Data_In[OP_HI:OP_LO] == HALT_OP) begin
          state_d = HALT;
        end
      end
    end else if (!Stall) begin
      // Halt word has been consumed by decode; nothing more is ever issued.
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= '0;
      vld_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      vld_q      <= vld_d;
    end
  end

  assign Address     = pc_q;
  assign Instr       = instr_q;
  assign Instr_PC    = instr_pc_q;
  assign Instr_Valid = vld_q;
  assign Halted      = (state_q == HALT);

endmodule

// File: tb/tb_prog_fetch.sv
// Bench for prog_fetch: directed scenarios plus random stall/branch/ROM traffic
// compared against a transaction-level fetch model.
module tb_prog_fetch;
  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [7:0]  Address;
  logic [26:0] Data_In;
  logic        Stall = 1'b0;
  logic        Branch_En = 1'b0;
  logic [7:0]  Branch_Target = 8'h00;
  logic [26:0] Instr;
  logic [7:0]  Instr_PC;
  logic        Instr_Valid;
  logic        Halted;

  logic [26:0] rom [256];
  int total = 0;
  int bad = 0;

  // Reference model: what decode should be seeing, in plain variables.
  logic [7:0]  m_pc;
  logic [26:0] m_instr;
  logic [7:0]  m_ipc;
  logic        m_vld;
  logic        m_halt;

  prog_fetch dut (
    .Clk(Clk), .Reset(Reset), .Address(Address), .Data_In(Data_In),
    .Stall(Stall), .Branch_En(Branch_En), .Branch_Target(Branch_Target),
    .Instr(Instr), .Instr_PC(Instr_PC), .Instr_Valid(Instr_Valid), .Halted(Halted)
  );

  assign Data_In = rom[Address];

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 8'h00; m_instr = '0; m_ipc = 8'h00; m_vld = 1'b0; m_halt = 1'b0;
  endtask

  // One clock of fetch behaviour, using the model's own PC to index the ROM.
  task automatic model_edge();
    if (m_halt) begin
      if (!Stall) m_vld = 1'b0;
    end else if (Branch_En) begin
      m_pc  = Branch_Target;
      m_vld = 1'b0;
    end else if (!Stall) begin
      m_instr = rom[m_pc];
      m_ipc   = m_pc;
      m_vld   = 1'b1;
      m_halt  = (rom[m_pc] >> 21) == 27'h3F;
      m_pc    = 8'((int'(m_pc) + 1) % 256);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".addr"},   32'(Address),     32'(m_pc));
    chk({tag, ".instr"},  32'(Instr),       32'(m_instr));
    chk({tag, ".ipc"},    32'(Instr_PC),    32'(m_ipc));
    chk({tag, ".vld"},    32'(Instr_Valid), 32'(m_vld));
    chk({tag, ".halted"}, 32'(Halted),      32'(m_halt));
  endtask

  task automatic tick(input string tag);
    @(posedge Clk);
    if (!Reset) model_edge();
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    model_reset();
    Branch_En = 1'b0;
    Stall = 1'b0;
    #1;
    check_model("rst_hold");
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
    #1;
    check_model("rst_rel");
  endtask

  task automatic init_rom();
    for (int a = 0; a < 256; a++) rom[a] = 27'(a);
  endtask

  initial begin
    init_rom();
    model_reset();

    // Reset then sequential fetch
    do_reset();
    chk("t1.addr0", 32'(Address), 32'h00);
    chk("t1.vld0", 32'(Instr_Valid), 32'h0);
    tick("t1.e1");
    chk("t1.instr0", 32'(Instr), 32'h0);
    chk("t1.ipc0", 32'(Instr_PC), 32'h00);
    chk("t1.vld1", 32'(Instr_Valid), 32'h1);
    chk("t1.addr1", 32'(Address), 32'h01);
    for (int i = 0; i < 3; i++) tick("t1.seq");
    chk("t1.ipc3", 32'(Instr_PC), 32'h03);

    // Stall holds everything
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) tick("t2.stall");
    chk("t2.instr", 32'(Instr), 32'h3);
    chk("t2.addr", 32'(Address), 32'h04);
    Stall = 1'b0;
    tick("t2.go");
    chk("t2.instr4", 32'(Instr), 32'h4);
    chk("t2.ipc4", 32'(Instr_PC), 32'h04);

    // Branch with one bubble, then branch while stalled
    Branch_En = 1'b1; Branch_Target = 8'h1E;
    tick("t3.br");
    Branch_En = 1'b0;
    chk("t3.bubble", 32'(Instr_Valid), 32'h0);
    chk("t3.addr", 32'(Address), 32'h1E);
    tick("t3.tgt");
    chk("t3.instr", 32'(Instr), 32'h1E);
    chk("t3.ipc", 32'(Instr_PC), 32'h1E);
    Stall = 1'b1; Branch_En = 1'b1; Branch_Target = 8'h2A;
    tick("t3.brst");
    Branch_En = 1'b0;
    chk("t3.st_bubble", 32'(Instr_Valid), 32'h0);
    chk("t3.st_addr", 32'(Address), 32'h2A);
    Stall = 1'b0;
    tick("t3.st_tgt");
    chk("t3.st_ipc", 32'(Instr_PC), 32'h2A);

    // PC wrap with no bubble
    Branch_En = 1'b1; Branch_Target = 8'hFE;
    tick("t4.br");
    Branch_En = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] want;
      want = 8'(8'hFE + i);
      tick("t4.run");
      chk("t4.wrap_ipc", 32'(Instr_PC), 32'(want));
      chk("t4.wrap_vld", 32'(Instr_Valid), 32'h1);
    end

    // Halt word at 06
    rom[6] = {6'h3F, 21'h0};
    do_reset();
    for (int i = 0; i < 7; i++) tick("t5.run");
    chk("t5.ipc", 32'(Instr_PC), 32'h06);
    chk("t5.vld", 32'(Instr_Valid), 32'h1);
    chk("t5.halted", 32'(Halted), 32'h1);
    chk("t5.addr", 32'(Address), 32'h07);
    Branch_En = 1'b1; Branch_Target = 8'h00;
    tick("t5.br_ign");
    Branch_En = 1'b0;
    chk("t5.addr_frozen", 32'(Address), 32'h07);
    chk("t5.vld_off", 32'(Instr_Valid), 32'h0);
    tick("t5.stay");
    chk("t5.still_halted", 32'(Halted), 32'h1);

    // Asynchronous reset between edges while halted
    @(posedge Clk);
    #3;
    Reset = 1'b1;
    model_reset();
    #1;
    chk("t6.addr", 32'(Address), 32'h00);
    chk("t6.halted", 32'(Halted), 32'h0);
    chk("t6.vld", 32'(Instr_Valid), 32'h0);
    chk("t6.instr", 32'(Instr), 32'h0);
    @(negedge Clk);
    Reset = 1'b0;
    rom[6] = 27'h6;
    tick("t6.restart");
    chk("t6.ipc0", 32'(Instr_PC), 32'h00);
    chk("t6.vld1", 32'(Instr_Valid), 32'h1);

    // Random traffic: random ROM contents with occasional halt words
    for (int a = 0; a < 256; a++) begin
      rom[a] = 27'($urandom);
      if ($urandom_range(0, 15) == 0) rom[a][26:21] = 6'h3F;
    end
    for (int c = 0; c < 600; c++) begin
      Stall         = ($urandom_range(0, 3) == 0);
      Branch_En     = ($urandom_range(0, 5) == 0);
      Branch_Target = 8'($urandom);
      if (m_halt && $urandom_range(0, 7) == 0) begin
        do_reset();
      end else begin
        tick("rnd");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
